// File: rtl/div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer: radix-2 restoring divider
// that stalls the core until the result is ready.
`timescale 1ns/1ps
module div_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_q, neg_d;
    logic              is_rem_q, is_rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              op_signed;
    logic              op_rem;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     rem_sh;
    logic              fits;
    logic [XLEN-1:0]   rem_new;
    logic [XLEN-1:0]   quo_new;
    logic [XLEN-1:0]   sel;

    // Operation decode and one restoring-division step
    always_comb begin
        op_signed = (funct3 == 3'b100) || (funct3 == 3'b110);
        op_rem    = (funct3 == 3'b110) || (funct3 == 3'b111);
        abs_a     = (op_signed && rs1[XLEN-1]) ? XLEN'(-rs1) : rs1;
        abs_b     = (op_signed && rs2[XLEN-1]) ? XLEN'(-rs2) : rs2;
        rem_sh    = {rem_q, quo_q[XLEN-1]};
        fits      = (rem_sh >= {1'b0, dvs_q});
        rem_new   = fits ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
        quo_new   = {quo_q[XLEN-2:0], fits};
        sel       = is_rem_q ? rem_new : quo_new;
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        is_rem_d = is_rem_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_rem_d = op_rem;
                    if (rs2 == '0) begin
                        state_d  = S_DONE;
                        quo_d    = '1;
                        rem_d    = rs1;
                        result_d = op_rem ? rs1 : '1;
                    end else if (op_signed && rs1 == INT_MIN && rs2 == '1) begin
                        state_d  = S_DONE;
                        quo_d    = INT_MIN;
                        rem_d    = '0;
                        result_d = op_rem ? '0 : INT_MIN;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        quo_d   = abs_a;
                        rem_d   = '0;
                        dvs_d   = abs_b;
                        neg_d   = op_signed &&
                                  (op_rem ? rs1[XLEN-1] : (rs1[XLEN-1] ^ rs2[XLEN-1]));
                    end
                end
            end
            S_CALC: begin
                quo_d = quo_new;
                rem_d = rem_new;
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = neg_q ? XLEN'(-sel) : sel;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            is_rem_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            neg_q    <= neg_d;
            is_rem_q <= is_rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Stall releases in the DONE cycle so the instruction retires once
    assign stall  = start && (state_q != S_DONE);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) in the single-cycle core.
- The decoder asserts start while a divide instruction sits in execute. The block stalls the core, meaning PC and register-file write are held, while a radix-2 restoring divider iterates one bit per cycle.
- Stall drops in the cycle the result is valid, so the instruction retires exactly once.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level; high while current instruction is a divide op
funct3  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; others treated as DIVU
rs1  input  XLEN  dividend
rs2  input  XLEN  divisor
stall  output  1  combinational; start && state!=DONE; holds PC/regfile write
busy  output  1  registered; high in CALC
done  output  1  registered; high only in DONE
result  output  XLEN  registered; valid when done=1, holds last value otherwise

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, busy=0, done=0, result=0, internal quotient/remainder/divisor regs=0. Applies mid-operation: the operation is abandoned with no partial result.
- States: IDLE, CALC, DONE.
- IDLE, start=0: stay in IDLE.
- IDLE, start=1: latch funct3, rs1, rs2; select the path:
  - divisor==0 -> DONE; quotient=all ones (0xFFFFFFFF, both signed and unsigned); remainder=rs1.
  - signed op, rs1=0x80000000, rs2=0xFFFFFFFF -> DONE; quotient=0x80000000, remainder=0.
  - otherwise -> CALC; counter=0; working dividend=|rs1| for signed ops, else rs1; working divisor likewise; partial remainder=0.
- CALC, each cycle:
  - shift {rem,quo} left one bit, bringing in the dividend MSB.
  - if shifted rem >= divisor (unsigned 33-bit compare): subtract, set quotient LSB=1; else quotient LSB=0.
  - counter increments; after the 32nd iteration (counter==31) -> DONE.
- DONE entry: result is registered from the selected output.
  - DIV/DIVU: quotient, negated if signed and sign(rs1)^sign(rs2).
  - REM/REMU: remainder, negated if signed and rs1 negative.
- DONE is held exactly one cycle, then -> IDLE unconditionally.
- Latency, normal path: start seen in cycle 0 (IDLE). CALC runs cycles 1..32. DONE in cycle 33. stall is high in cycles 0..32 and low in 33. 33 stall cycles total.
- Latency, special cases: stall high in cycle 0, DONE in cycle 1. 1 stall cycle.
- Back-to-back divides: if start is high in the IDLE cycle after DONE, a new operation begins with the new operands. The core advanced PC during DONE.
- start dropping during CALC (not legal from the core): the operation continues to DONE, stall follows start and goes low, and the result is ignored.
- Operands and funct3 are sampled only on the IDLE->CALC/DONE transition. Changes during CALC have no effect.
- All arithmetic is unsigned on magnitudes; sign fix-up is applied only at DONE entry. No X propagation from unused funct3 values.

Test Plan:
- DIVU rs1=100, rs2=7 -> stall high 33 cycles; done in cycle 33; result=14. REMU same operands -> result=2.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> result=0xFFFFFFFD (-3). REM same operands -> result=0xFFFFFFFF (-1).
- DIV rs1=5, rs2=0 -> DONE in cycle 1; result=0xFFFFFFFF. REMU rs1=5, rs2=0 -> result=5. Exactly 1 stall cycle each.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> result=0x80000000 in cycle 1. REM same operands -> result=0.
- Back-to-back: DIVU 100/7, then start held into the next IDLE with DIVU 0xFFFFFFFF/1 -> first done at cycle 33 (14); second done at cycle 67 (0xFFFFFFFF); stall low only in cycles 33 and 67.
- Assert rst at cycle 10 of CALC -> state=IDLE, busy=0, done=0, result=0 immediately (async). After release, a fresh DIVU 9/3 yields result=3 in 33 cycles.
